sys_if_arbiter: RTL and testbench
=================================

Name: sys_if_arbiter

Overview:
- Round-robin arbiter sharing one sys_if register bus (wen/addr/wdata/rdata) among NUM_REQ requesters, e.g. host bridge, clock-recovery sequencer, self-test engine.
- Sits upstream of the sys_if address-decode switch that fans the bus out to the eight 64 KB regions selected by addr[31:16].
- Serialises accesses, holds address stable for reads, captures read data and returns a per-requester response pulse.

Parameters:
- NUM_REQ, 4, number of requesters, 2..8.
- RD_WAIT, 2, cycles address is held before sys_if_rdata is sampled, 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronous to clk.
- req_valid  in  NUM_REQ  per-requester access request.
- req_wr  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*32  packed addresses; requester i at [32i+31:32i].
- req_wdata  in  NUM_REQ*32  packed write data.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_rdata  out  32  read data, valid with rsp_valid; 0 for writes.
- sys_if_wen  out  1  write strobe to switch.
- sys_if_addr  out  32  address to switch.
- sys_if_wdata  out  32  write data to switch.
- sys_if_rdata  in  32  combinational read data from switch.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, sys_if_wen=0, sys_if_addr=0, sys_if_wdata=0, busy=0, state=IDLE, rr_ptr=NUM_REQ-1, so requester 0 wins first.
- Reset asserted mid-transaction aborts it immediately. sys_if_wen drops asynchronously and no rsp_valid is issued.
- IDLE state:
  - If any req_valid is high, grant the first valid index searching upward from rr_ptr+1, wrapping modulo NUM_REQ.
  - Same cycle: req_ready[g]=1 for one cycle. Register addr, wdata and wr of g into sys_if_addr, sys_if_wdata and the internal wr flag. rr_ptr<=g.
  - Next state is WRITE if wr, else READ.
- WRITE state: sys_if_wen=1 for exactly one cycle; next state RESP; rsp_rdata<=0.
- READ state:
  - sys_if_wen=0; sys_if_addr held stable.
  - Counter loads RD_WAIT-1 on entry and decrements each cycle.
  - When the counter reaches 0, sample sys_if_rdata into rsp_rdata; next state RESP.
- RESP state: rsp_valid[g]=1 for one cycle; next state IDLE.
- Latency, with acceptance at cycle T:
  - Write: wen at T+1, rsp_valid at T+2.
  - Read: addr valid from T+1, rsp_valid at T+1+RD_WAIT.
- One transaction outstanding at a time. No grant is issued outside IDLE. Minimum spacing between accepts is 3 cycles.
- Requester protocol:
  - A requester holds req_valid, req_wr, req_addr and req_wdata stable until req_ready.
  - Dropping req_valid before req_ready withdraws the request; no response follows.
- sys_if_addr and sys_if_wdata keep their last values while idle; sys_if_wen is never high outside WRITE.
- Round-robin wrap: with all requesters valid, grant order is 0,1,..,NUM_REQ-1,0. A lone requester is granted back-to-back.
- The arbiter is address-agnostic: unmapped regions (addr[31:16]>7) complete normally with the switch's 0 read data.

Optional Feature:
- Macro: SYS_IF_ARB_LOCK_EN.
- Defined:
  - Adds input req_lock [NUM_REQ-1:0].
  - If req_lock[g] is high in RESP, the arbiter enters locked mode. In IDLE it then considers only requester g and waits while req_valid[g]=0.
  - The lock releases on the first IDLE cycle with req_lock[g]=0; normal round-robin resumes from rr_ptr=g.
  - Enables atomic read-modify-write.
- Not defined: port absent, pure round-robin.

Test Plan:
- Single write: requester 1 writes addr 0x0003_0010, data 0xA5A5_0001 at T -> req_ready[1] at T; sys_if_wen=1 with addr/data at T+1 only; rsp_valid[1] at T+2 with rsp_rdata=0.
- Read with RD_WAIT=2: requester 0 reads 0x0005_0004; switch returns 0x1234_5678 -> addr stable T+1..T+2; rsp_valid[0] at T+3 with rsp_rdata=0x1234_5678.
- Contention: all four requesters assert valid simultaneously from reset -> grants 0,1,2,3 in order, each accept 3 cycles apart for writes; re-asserting all repeats 0,1,2,3.
- Withdrawal and wrap: requester 3 is the last grant; requesters 0 and 2 valid -> 0 granted next; requester 2 drops valid before its grant -> no req_ready[2], no rsp_valid[2].
- Reset mid-read: rst_n low during READ -> sys_if_wen=0, busy=0, no rsp_valid; after release, requester 0 has first priority.
- Lock (macro defined): requester 2 reads with req_lock[2]=1 while requester 0 is valid -> requester 0 is not granted; requester 2's following write is granted next; after lock drops, requester 0 is granted.

Source files
------------

// File: rtl/sys_if_arbiter.sv
// sys_if_arbiter: round-robin arbiter sharing one sys_if register bus among NUM_REQ requesters.
// Optional macro SYS_IF_ARB_LOCK_EN adds req_lock so one requester can hold the bus for read-modify-write.
module sys_if_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int RD_WAIT = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_wr,
   input  logic [NUM_REQ*32-1:0] req_addr,
   input  logic [NUM_REQ*32-1:0] req_wdata,
`ifdef SYS_IF_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]    req_lock,
`endif
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  sys_if_wen,
   output logic [31:0]           sys_if_addr,
   output logic [31:0]           sys_if_wdata,
   input  logic [31:0]           sys_if_rdata,
   output logic                  busy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   state_t                   state, state_nxt;
   logic [IW-1:0]            rr_ptr, gnt_idx, cand;
   logic                     gnt_any;
   logic [3:0]               cnt;
   logic [NUM_REQ-1:0][31:0] addr_v, wdata_v;

   assign addr_v  = req_addr;
   assign wdata_v = req_wdata;

`ifdef SYS_IF_ARB_LOCK_EN
   logic locked, lock_hold;

   // Lock is re-evaluated at every response; it drops on the first idle cycle without req_lock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         locked <= 1'b0;
      else if (state == RESP)
         locked <= req_lock[rr_ptr];
      else if (state == IDLE && !req_lock[rr_ptr])
         locked <= 1'b0;
   end

   assign lock_hold = locked & req_lock[rr_ptr];
`endif

   // Walk downward so the last hit is the nearest index above rr_ptr.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = rr_ptr;
      cand    = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
         if (req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
`ifdef SYS_IF_ARB_LOCK_EN
      if (lock_hold) begin
         gnt_any = req_valid[rr_ptr];
         gnt_idx = rr_ptr;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      rsp_valid = '0;
      case (state)
         IDLE: begin
            if (gnt_any) begin
               req_ready[gnt_idx] = 1'b1;
               state_nxt          = req_wr[gnt_idx] ? WRITE : READ;
            end
         end
         WRITE: state_nxt = RESP;
         READ:  if (cnt == 4'd0) state_nxt = RESP;
         RESP: begin
            rsp_valid[rr_ptr] = 1'b1;
            state_nxt         = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // rr_ptr doubles as the current owner index from grant through response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr       <= IW'(NUM_REQ - 1);
         sys_if_addr  <= '0;
         sys_if_wdata <= '0;
         rsp_rdata    <= '0;
         cnt          <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  rr_ptr       <= gnt_idx;
                  sys_if_addr  <= addr_v[gnt_idx];
                  sys_if_wdata <= wdata_v[gnt_idx];
                  cnt          <= 4'(RD_WAIT - 1);
               end
            end
            WRITE: rsp_rdata <= '0;
            READ: begin
               if (cnt == 4'd0)
                  rsp_rdata <= sys_if_rdata;
               else
                  cnt <= cnt - 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign sys_if_wen = (state == WRITE);
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_sys_if_arbiter.sv
// Scoreboard bench for sys_if_arbiter: stimulus queues expected grants/writes/responses, a monitor pops them.
// Define SYS_IF_ARB_LOCK_EN for both files to also exercise the lock sequence.
module tb_sys_if_arbiter;
   localparam int N  = 4;
   localparam int RW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_wr = '0;
   logic [N*32-1:0] req_addr = '0;
   logic [N*32-1:0] req_wdata = '0;
`ifdef SYS_IF_ARB_LOCK_EN
   logic [N-1:0]    req_lock = '0;
`endif
   logic [N-1:0]    req_ready, rsp_valid;
   logic [31:0]     rsp_rdata, sys_if_addr, sys_if_wdata, sys_if_rdata;
   logic            sys_if_wen, busy;

   sys_if_arbiter #(.NUM_REQ(N), .RD_WAIT(RW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef SYS_IF_ARB_LOCK_EN
      .req_lock(req_lock),
`endif
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .sys_if_wen(sys_if_wen), .sys_if_addr(sys_if_addr), .sys_if_wdata(sys_if_wdata),
      .sys_if_rdata(sys_if_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // Switch model: a few fixed registers, 0 for unmapped regions.
   function automatic logic [31:0] sw_read(input logic [31:0] a);
      if (a[31:16] > 16'd7) return 32'h0;
      case (a)
         32'h0005_0004: return 32'h1234_5678;
         32'h0002_0008: return 32'hCAFE_F00D;
         default:       return 32'h1111_1111;
      endcase
   endfunction
   always_comb sys_if_rdata = sw_read(sys_if_addr);

   typedef struct { int idx; int gap; } g_t;
   typedef struct { logic [31:0] a; logic [31:0] d; } w_t;
   typedef struct { int idx; logic [31:0] rd; int lat; } r_t;
   g_t gq[$];
   w_t wq[$];
   r_t rq[$];

   int          errors = 0, checks = 0, cyc = 0, acc_cyc = 0;
   logic [31:0] last_addr = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Requester agent: drop req_valid on the cycle after req_ready.
   initial begin
      logic [N-1:0] rdy;
      forever begin
         @(negedge clk);
         rdy = req_ready;
         @(posedge clk);
         #1;
         req_valid = req_valid & ~rdy;
      end
   end

   // Monitor
   initial begin
      g_t g;
      w_t w;
      r_t r;
      forever begin
         @(negedge clk);
         if (!rst_n) continue;
         chk("addr_hold", sys_if_addr, last_addr);
         if (|req_ready) begin
            if (gq.size() == 0) chk("unexpected_ready", 32'(req_ready), 32'h0);
            else begin
               g = gq.pop_front();
               chk("grant", 32'(req_ready), 32'(1) << g.idx);
               if (g.gap != 0) chk("accept_gap", cyc - acc_cyc, g.gap);
               acc_cyc   = cyc;
               last_addr = req_addr[g.idx*32 +: 32];
            end
         end
         if (sys_if_wen) begin
            if (wq.size() == 0) chk("unexpected_wen", 32'(sys_if_wen), 32'h0);
            else begin
               w = wq.pop_front();
               chk("wen_cycle", cyc - acc_cyc, 1);
               chk("wen_addr", sys_if_addr, w.a);
               chk("wen_data", sys_if_wdata, w.d);
            end
         end
         if (|rsp_valid) begin
            if (rq.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
            else begin
               r = rq.pop_front();
               chk("rsp_idx", 32'(rsp_valid), 32'(1) << r.idx);
               chk("rsp_rdata", rsp_rdata, r.rd);
               chk("rsp_latency", cyc - acc_cyc, r.lat);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic expect_txn(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] rd, input int gap);
      gq.push_back('{i, gap});
      if (wr) wq.push_back('{a, d});
      rq.push_back('{i, wr ? 32'h0 : rd, wr ? 2 : 1 + RW});
   endtask

   task automatic drive(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
      req_wr[i]              = wr;
      req_addr[i*32 +: 32]   = a;
      req_wdata[i*32 +: 32]  = d;
      req_valid[i]           = 1'b1;
   endtask

   task automatic wait_accept(input int i);
      for (int n = 0; n < 60; n++) begin
         step();
         if (!req_valid[i]) return;
      end
      timeout("wait_accept");
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 200; n++) begin
         step();
         if (gq.size() == 0 && wq.size() == 0 && rq.size() == 0 && !busy && req_valid == '0) return;
      end
      timeout("wait_idle");
      gq.delete(); wq.delete(); rq.delete();
      req_valid = '0;
   endtask

   task automatic do_reset();
      req_valid = '0;
      rst_n     = 1'b0;
      #1;
      chk("rst_wen", 32'(sys_if_wen), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      gq.delete(); wq.delete(); rq.delete();
      last_addr = '0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst_n = 1'b0;
      step();
      step();
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_addr", sys_if_addr, 32'h0);
      chk("rst_wdata", sys_if_wdata, 32'h0);
      chk("rst_wen0", 32'(sys_if_wen), 32'h0);
      chk("rst_busy0", 32'(busy), 32'h0);
      chk("rst_ready0", 32'(req_ready), 32'h0);
      chk("rst_rsp0", 32'(rsp_valid), 32'h0);
      rst_n = 1'b1;
      step();

      // Contention from reset: two rounds of 0,1,2,3 writes, 3 cycles apart.
      for (int rnd = 0; rnd < 2; rnd++) begin
         for (int i = 0; i < N; i++)
            expect_txn(i, 1'b1, 32'h0001_0100 + 32'(i * 4), 32'hD000_0000 + 32'(rnd * 16 + i), '0, i == 0 ? 0 : 3);
         for (int i = 0; i < N; i++)
            drive(i, 1'b1, 32'h0001_0100 + 32'(i * 4), 32'hD000_0000 + 32'(rnd * 16 + i));
         wait_idle();
      end

      // Single write from requester 1.
      expect_txn(1, 1'b1, 32'h0003_0010, 32'hA5A5_0001, '0, 0);
      drive(1, 1'b1, 32'h0003_0010, 32'hA5A5_0001);
      wait_idle();

      // Read from requester 0, then an unmapped read from requester 1.
      expect_txn(0, 1'b0, 32'h0005_0004, '0, 32'h1234_5678, 0);
      drive(0, 1'b0, 32'h0005_0004, '0);
      wait_idle();
      expect_txn(1, 1'b0, 32'h0009_0000, '0, 32'h0, 0);
      drive(1, 1'b0, 32'h0009_0000, '0);
      wait_idle();

      // Wrap and withdrawal: 3 last, then 0 and 2 valid, 2 withdraws before its grant.
      expect_txn(3, 1'b1, 32'h0007_FFFC, 32'h3333_0003, '0, 0);
      drive(3, 1'b1, 32'h0007_FFFC, 32'h3333_0003);
      wait_idle();
      expect_txn(0, 1'b1, 32'h0000_0040, 32'h0000_00AA, '0, 0);
      drive(0, 1'b1, 32'h0000_0040, 32'h0000_00AA);
      drive(2, 1'b1, 32'h0006_0000, 32'h2222_2222);
      wait_accept(0);
      req_valid[2] = 1'b0;
      wait_idle();
      repeat (6) step();

      // Lone requester granted back-to-back.
      expect_txn(2, 1'b1, 32'h0004_0000, 32'h4444_0001, '0, 0);
      expect_txn(2, 1'b1, 32'h0004_0004, 32'h4444_0002, '0, 3);
      drive(2, 1'b1, 32'h0004_0000, 32'h4444_0001);
      wait_accept(2);
      drive(2, 1'b1, 32'h0004_0004, 32'h4444_0002);
      wait_idle();

      // Reset during READ, then requester 0 has first priority.
      expect_txn(1, 1'b0, 32'h0002_0008, '0, 32'hCAFE_F00D, 0);
      drive(1, 1'b0, 32'h0002_0008, '0);
      wait_accept(1);
      chk("read_busy", 32'(busy), 32'h1);
      do_reset();
      expect_txn(0, 1'b1, 32'h0000_0080, 32'h0BAD_0000, '0, 0);
      expect_txn(3, 1'b1, 32'h0003_0080, 32'h0BAD_0003, '0, 3);
      drive(3, 1'b1, 32'h0003_0080, 32'h0BAD_0003);
      drive(0, 1'b1, 32'h0000_0080, 32'h0BAD_0000);
      wait_idle();

      // Reset during WRITE: wen must fall without a clock edge.
      expect_txn(2, 1'b1, 32'h0001_0000, 32'h5555_5555, '0, 0);
      drive(2, 1'b1, 32'h0001_0000, 32'h5555_5555);
      wait_accept(2);
      chk("wen_pre_rst", 32'(sys_if_wen), 32'h1);
      do_reset();

`ifdef SYS_IF_ARB_LOCK_EN
      // Locked read by 2 keeps 0 out until 2's follow-up write and lock release.
      expect_txn(2, 1'b0, 32'h0002_0008, '0, 32'hCAFE_F00D, 0);
      expect_txn(2, 1'b1, 32'h0002_0008, 32'hCAFE_F00E, '0, 0);
      expect_txn(0, 1'b1, 32'h0000_0010, 32'h0000_0001, '0, 3);
      req_lock[2] = 1'b1;
      drive(2, 1'b0, 32'h0002_0008, '0);
      wait_accept(2);
      drive(0, 1'b1, 32'h0000_0010, 32'h0000_0001);
      for (int n = 0; n < 40 && rq.size() > 2; n++) step();
      repeat (6) step();
      chk("lock_no_grant0", 32'(req_valid[0]), 32'h1);
      drive(2, 1'b1, 32'h0002_0008, 32'hCAFE_F00E);
      wait_accept(2);
      req_lock[2] = 1'b0;
      wait_idle();
`endif

      repeat (4) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
